fetch_queue: RTL and testbench

Instruction prefetch queue sitting between the instruction memory and the IF/ID pipeline register, directly upstream of decode. It runs a one-outstanding request/acknowledge handshake toward a variable-latency instruction memory and buffers up to DEPTH fetched instructions with their PCs. It presents the oldest entry to the IF/ID register. It also absorbs branch/jump redirects from the ID-stage branch unit by flushing buffered and in-flight instructions.

---
 rtl/fetch_queue.sv | 91 +++++++++
 tb/tb_fetch_queue.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between a variable-latency memory and IF/ID.
// Define FETCH_QUEUE_BYPASS_EN to forward an ack straight to out_* when the queue is empty.
module fetch_queue #(
    parameter int                  DEPTH      = 4,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    input  logic                  deq,
    output logic                  out_valid,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [DATA_WIDTH-1:0] out_instruction,
    output logic [PC_WIDTH-1:0]   out_nextPC,
    output logic                  mem_req,
    output logic [PC_WIDTH-1:0]   mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic                  mem_req_q;
    logic [AW-1:0]         head_q, tail_q;
    logic [AW:0]           count_q, count_d;
    logic [PC_WIDTH-1:0]   pc_q  [DEPTH];
    logic [DATA_WIDTH-1:0] ins_q [DEPTH];
    logic                  ack_ok, byp, push, pop;

    assign ack_ok = state_q == REQ && mem_ack && !redirect;
`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = ack_ok && count_q == '0;
`else
    assign byp = 1'b0;
`endif
    // a bypassed entry consumed in its ack cycle never touches the buffer
    assign push = ack_ok && !(byp && deq);
    assign pop  = deq && count_q != '0 && !redirect;

    always_comb begin
        count_d    = redirect ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
        fetch_pc_d = redirect ? redirect_pc : ack_ok ? fetch_pc_q + PC_WIDTH'(4) : fetch_pc_q;
        state_d    = state_q == DROP ? (mem_ack ? REQ : DROP) :
                     (state_q == REQ && redirect && !mem_ack) ? DROP :
                     (count_d < (AW+1)'(DEPTH)) ? REQ : IDLE;
        // DROP keeps the abandoned address on the bus until its ack arrives
        mem_addr_d = state_d == DROP ? mem_addr_q : fetch_pc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]  <= '0;
                ins_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= state_d != IDLE;
            mem_addr_q <= mem_addr_d;
            count_q    <= count_d;
            head_q     <= redirect ? '0 : head_q + AW'(pop);
            tail_q     <= redirect ? '0 : tail_q + AW'(push);
            if (push) begin
                pc_q[tail_q]  <= fetch_pc_q;
                ins_q[tail_q] <= mem_rdata;
            end
        end
    end

    assign mem_req         = mem_req_q;
    assign mem_addr        = mem_addr_q;
    assign out_valid       = count_q != '0 || byp;
    assign out_pc          = byp ? fetch_pc_q : pc_q[head_q];
    assign out_instruction = byp ? mem_rdata : ins_q[head_q];
    assign out_nextPC      = out_pc + PC_WIDTH'(4);
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue with a latency-programmable memory model.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        deq = 1'b0;
    logic        out_valid, mem_req, mem_ack;
    logic [31:0] out_pc, out_instruction, out_nextPC, mem_addr, mem_rdata;
    int          lat = 0;
    int          wcnt = 0;
    int          ack_cnt = 0;
    int          checked = 0;
    int          errs = 0;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq),
        .out_valid(out_valid), .out_pc(out_pc), .out_instruction(out_instruction),
        .out_nextPC(out_nextPC), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // memory acks after lat wait cycles; instruction word is the inverted address
    assign mem_ack   = mem_req && wcnt >= lat;
    assign mem_rdata = ~mem_addr;

    always @(posedge clk) begin
        wcnt    <= (rst || !mem_req || mem_ack) ? 0 : wcnt + 1;
        ack_cnt <= rst ? 0 : ack_cnt + int'(mem_ack);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checked++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        deq = 1'b0;
        redirect = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_ins", out_instruction, 32'h0);
        chk("rst_next", out_nextPC, 32'h4);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // streaming with zero-wait memory and deq held high
        lat = 0;
        do_reset();
        deq = 1'b1;
        chk("idle_req", 32'(mem_req), 0);
        step();
        chk("first_req", 32'(mem_req), 1);
        chk("first_addr", mem_addr, 32'h0);
        chk("first_valid", 32'(out_valid), 0);
        step();
        for (int k = 0; k < 6; k++) begin
            chk("stream_valid", 32'(out_valid), 1);
            chk("stream_pc", out_pc, 32'(4 * k));
            chk("stream_next", out_nextPC, 32'(4 * k + 4));
            chk("stream_ins", out_instruction, ~32'(4 * k));
            step();
        end

        // fill to DEPTH with deq low, then one deq pulse
        do_reset();
        repeat (6) step();
        chk("full_acks", 32'(ack_cnt), 4);
        chk("full_req", 32'(mem_req), 0);
        chk("full_addr", mem_addr, 32'h10);
        chk("full_head", out_pc, 32'h0);
        deq = 1'b1;
        step();
        deq = 1'b0;
        chk("pulse_req", 32'(mem_req), 1);
        chk("pulse_addr", mem_addr, 32'h10);
        chk("pulse_head", out_pc, 32'h4);
        step();
        chk("refill_acks", 32'(ack_cnt), 5);
        chk("refill_req", 32'(mem_req), 0);
        repeat (3) step();
        chk("hold_acks", 32'(ack_cnt), 5);

        // redirect during a slow fetch goes through DROP
        lat = 3;
        do_reset();
        step();
        step();
        redirect = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk("drop_req", 32'(mem_req), 1);
        chk("drop_addr", mem_addr, 32'h0);
        step();
        chk("drop_ack_addr", mem_addr, 32'h0);
        chk("drop_valid", 32'(out_valid), 0);
        step();
        chk("redir_addr", mem_addr, 32'h100);
        chk("redir_valid", 32'(out_valid), 0);
        for (int i = 0; i < 10 && !out_valid; i++) step();
        chk("redir_out_valid", 32'(out_valid), 1);
        chk("redir_out_pc", out_pc, 32'h100);
        chk("redir_out_ins", out_instruction, ~32'h100);

        // redirect + deq + ack in one cycle with two entries queued
        lat = 0;
        do_reset();
        repeat (3) step();
        chk("two_head", out_pc, 32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        deq = 1'b1;
        step();
        redirect = 1'b0;
        deq = 1'b0;
        chk("rda_valid", 32'(out_valid), 0);
        chk("rda_req", 32'(mem_req), 1);
        chk("rda_addr", mem_addr, 32'h200);
        step();
        chk("rda_out_valid", 32'(out_valid), 1);
        chk("rda_out_pc", out_pc, 32'h200);

        // wrap-around with interleaved dequeues
        do_reset();
        exp_pc = 32'h0;
        for (int i = 0; i < 60 && exp_pc < 32'd40; i++) begin
            deq = ((i * 7) % 5) < 3;
            if (deq && out_valid) begin
                chk("wrap_pc", out_pc, exp_pc);
                chk("wrap_ins", out_instruction, ~exp_pc);
                exp_pc += 32'd4;
            end
            step();
        end
        deq = 1'b0;
        chk("wrap_count", exp_pc, 32'd40);

        // reset while in DROP
        lat = 3;
        do_reset();
        step();
        redirect = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        chk("pre_rst_addr", mem_addr, 32'h0);
        chk("pre_rst_req", 32'(mem_req), 1);
        rst = 1'b1;
        step();
        chk("drst_valid", 32'(out_valid), 0);
        chk("drst_req", 32'(mem_req), 0);
        chk("drst_addr", mem_addr, 32'h0);
        chk("drst_pc", out_pc, 32'h0);
        chk("drst_next", out_nextPC, 32'h4);
        rst = 1'b0;
        step();
        chk("restart_req", 32'(mem_req), 1);
        chk("restart_addr", mem_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checked, errs);
        $finish;
    end
endmodule
